// File: rtl/axis_nco_sweep_ctrl.sv
// Frequency-sweep scheduler for the NCO phase-increment AXI-Stream input.
// Steps the tuning word from start to stop, holding each value for a set number of accepted beats.
module axis_nco_sweep_ctrl #(
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [31:0]            cfg_start_inc,
  input  logic [31:0]            cfg_stop_inc,
  input  logic [31:0]            cfg_step_inc,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [31:0]            m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sweep_count,
  output logic [COUNT_WIDTH-1:0] step_index
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] ModeRepeat = 2'd1;
  localparam logic [1:0] ModeBounce = 2'd2;

  state_e                 state_q, state_d;
  logic [31:0]            tdata_q, tdata_d;
  logic [31:0]            start_q, start_d;
  logic [31:0]            stop_q, stop_d;
  logic [31:0]            step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_max_q, dwell_max_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   dir_up_q, dir_up_d;
  logic [COUNT_WIDTH-1:0] sweep_count_q, sweep_count_d;
  logic [COUNT_WIDTH-1:0] step_index_q, step_index_d;

  logic        beat;
  logic        dwell_end;
  logic        at_stop;
  logic [31:0] fwd_next;
  logic [31:0] rev_next;

  // Move cur by step toward target; any overshoot or 32-bit wrap clamps to target.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] step,
                                              input logic [31:0] target,
                                              input logic        up);
    logic [32:0] sum;
    logic [31:0] res;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
      res = (sum[32] || (sum[31:0] > target)) ? target : sum[31:0];
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
      res = (sum[32] || (sum[31:0] < target)) ? target : sum[31:0];
    end
    return res;
  endfunction

  assign beat      = (state_q == StRun) && m_axis_data_tready;
  assign dwell_end = beat && (dwell_cnt_q == dwell_max_q);
  assign at_stop   = (tdata_q == stop_q);
  assign fwd_next  = step_toward(tdata_q, step_q, stop_q, dir_up_q);
  // Bounce turnaround steps straight off the endpoint toward the old start.
  assign rev_next  = step_toward(tdata_q, step_q, start_q, ~dir_up_q);

  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata_q;
    start_d       = start_q;
    stop_d        = stop_q;
    step_d        = step_q;
    dwell_max_d   = dwell_max_q;
    dwell_cnt_d   = dwell_cnt_q;
    mode_d        = mode_q;
    dir_up_d      = dir_up_q;
    sweep_count_d = sweep_count_q;
    step_index_d  = step_index_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          start_d       = cfg_start_inc;
          stop_d        = cfg_stop_inc;
          step_d        = cfg_step_inc;
          mode_d        = cfg_mode;
          dir_up_d      = (cfg_stop_inc >= cfg_start_inc);
          dwell_max_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_WIDTH'(1);
          dwell_cnt_d   = '0;
          tdata_d       = cfg_start_inc;
          sweep_count_d = '0;
          step_index_d  = '0;
          state_d       = StRun;
        end
      end

      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (dwell_end) begin
          dwell_cnt_d = '0;
          if (!at_stop) begin
            tdata_d      = fwd_next;
            step_index_d = step_index_q + COUNT_WIDTH'(1);
          end else begin
            sweep_count_d = sweep_count_q + COUNT_WIDTH'(1);
            step_index_d  = '0;
            if (mode_q == ModeRepeat) begin
              tdata_d = start_q;
            end else if (mode_q == ModeBounce) begin
              start_d  = stop_q;
              stop_d   = start_q;
              dir_up_d = ~dir_up_q;
              tdata_d  = rev_next;
            end else begin
              state_d = StDone;
            end
          end
        end else if (beat) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q       <= StIdle;
      tdata_q       <= '0;
      start_q       <= '0;
      stop_q        <= '0;
      step_q        <= '0;
      dwell_max_q   <= '0;
      dwell_cnt_q   <= '0;
      mode_q        <= '0;
      dir_up_q      <= 1'b1;
      sweep_count_q <= '0;
      step_index_q  <= '0;
    end else begin
      state_q       <= state_d;
      tdata_q       <= tdata_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      step_q        <= step_d;
      dwell_max_q   <= dwell_max_d;
      dwell_cnt_q   <= dwell_cnt_d;
      mode_q        <= mode_d;
      dir_up_q      <= dir_up_d;
      sweep_count_q <= sweep_count_d;
      step_index_q  <= step_index_d;
    end
  end

  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = (state_q == StRun);
  assign busy               = (state_q == StRun);
  assign done               = (state_q == StDone);
  assign sweep_count        = sweep_count_q;
  assign step_index         = step_index_q;

endmodule

// File: tb/tb_axis_nco_sweep_ctrl.sv
// Directed bench for axis_nco_sweep_ctrl: one task per scenario, inline checks.
module tb_axis_nco_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        arst;
  logic [31:0] cfg_start_inc, cfg_stop_inc, cfg_step_inc;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        start, abort;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic        busy, done;
  logic [15:0] sweep_count, step_index;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] beat_q[$];
  int          stall_err = 0;
  int          done_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  always #5 aclk = ~aclk;

  axis_nco_sweep_ctrl #(
    .DWELL_WIDTH(16),
    .COUNT_WIDTH(16)
  ) dut (
    .aclk              (aclk),
    .arst              (arst),
    .cfg_start_inc     (cfg_start_inc),
    .cfg_stop_inc      (cfg_stop_inc),
    .cfg_step_inc      (cfg_step_inc),
    .cfg_dwell         (cfg_dwell),
    .cfg_mode          (cfg_mode),
    .start             (start),
    .abort             (abort),
    .m_axis_data_tdata (m_tdata),
    .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .busy              (busy),
    .done              (done),
    .sweep_count       (sweep_count),
    .step_index        (step_index)
  );

  // Beat capture, stall-stability and done-pulse monitor.
  always @(posedge aclk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1) beat_q.push_back(m_tdata);
    if (prev_stall === 1'b1 && m_tvalid === 1'b1 && m_tdata !== prev_data)
      stall_err <= stall_err + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    prev_stall <= (m_tvalid === 1'b1) && (m_tready !== 1'b1);
    prev_data  <= m_tdata;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                      input logic [15:0] dw, input logic [1:0] md);
    cfg_start_inc = s;
    cfg_stop_inc  = e;
    cfg_step_inc  = st;
    cfg_dwell     = dw;
    cfg_mode      = md;
    start         = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; start = 1'b0; abort = 1'b0; m_tready = 1'b1;
    cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step_inc = '0; cfg_dwell = '0; cfg_mode = '0;
    repeat (3) tick();
    arst = 1'b0;
    n_total++;
    if ({m_tdata, m_tvalid, busy, done, sweep_count, step_index} !== 67'd0)
      $display("FAIL reset_state got %h %b%b%b %h %h want all zero",
               m_tdata, m_tvalid, busy, done, sweep_count, step_index);
    else n_pass++;
  endtask

  task automatic test_single_up();
    logic [31:0] exp_v[$];
    bit seen;
    for (int i = 0; i < 12; i++) exp_v.push_back(32'(100 * (i / 3 + 1)));
    m_tready = 1'b1;
    beat_q.delete();
    kick(100, 400, 100, 3, 0);
    n_total++;
    if ({busy, m_tvalid, m_tdata} !== {2'b11, 32'd100})
      $display("FAIL single_first got %b%b %0d want 11 100", busy, m_tvalid, m_tdata);
    else n_pass++;
    wait_done(100, seen);
    n_total++;
    if (!seen) $display("FAIL single_done got 0 want 1");
    else n_pass++;
    n_total++;
    if ({m_tvalid, busy, sweep_count} !== {2'b00, 16'd1})
      $display("FAIL single_done_outs got %b%b %0d want 00 1", m_tvalid, busy, sweep_count);
    else n_pass++;
    n_total++;
    if (beat_q.size() != 12) $display("FAIL single_nbeats got %0d want 12", beat_q.size());
    else n_pass++;
    for (int i = 0; i < exp_v.size() && i < beat_q.size(); i++) begin
      n_total++;
      if (beat_q[i] !== exp_v[i])
        $display("FAIL single_beat%0d got %0d want %0d", i, beat_q[i], exp_v[i]);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({done, m_tvalid, m_tdata} !== {2'b00, 32'd400})
      $display("FAIL single_idle got %b%b %0d want 00 400", done, m_tvalid, m_tdata);
    else n_pass++;
  endtask

  task automatic test_clamp_down_overflow();
    logic [31:0] s_t[3]  = '{32'd0, 32'd400, 32'hFFFF_FF00};
    logic [31:0] e_t[3]  = '{32'd250, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] st_t[3] = '{32'd100, 32'd150, 32'h80};
    int          len_t[3] = '{4, 3, 3};
    logic [31:0] exp_t[10] = '{32'd0, 32'd100, 32'd200, 32'd250, 32'd400, 32'd250, 32'd100,
                               32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF};
    int base = 0;
    bit seen;
    m_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      beat_q.delete();
      kick(s_t[c], e_t[c], st_t[c], 1, 0);
      wait_done(50, seen);
      n_total++;
      if (!seen || beat_q.size() != len_t[c])
        $display("FAIL clamp%0d_len got done=%0d n=%0d want done=1 n=%0d",
                 c, seen, beat_q.size(), len_t[c]);
      else n_pass++;
      for (int i = 0; i < len_t[c] && i < beat_q.size(); i++) begin
        n_total++;
        if (beat_q[i] !== exp_t[base + i])
          $display("FAIL clamp%0d_beat%0d got %h want %h", c, i, beat_q[i], exp_t[base + i]);
        else n_pass++;
      end
      base += len_t[c];
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_v[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int err0 = stall_err;
    bit seen = 1'b0;
    m_tready = 1'b0;
    beat_q.delete();
    kick(0, 3, 1, 2, 0);
    for (int i = 0; i < 500; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_tready = 1'b1;
    n_total++;
    if (!seen || beat_q.size() != 8)
      $display("FAIL bp_len got done=%0d n=%0d want done=1 n=8", seen, beat_q.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < beat_q.size(); i++) begin
      n_total++;
      if (beat_q[i] !== exp_v[i]) $display("FAIL bp_beat%0d got %0d want %0d", i, beat_q[i], exp_v[i]);
      else n_pass++;
    end
    n_total++;
    if (stall_err != err0) $display("FAIL bp_stable got %0d changes want 0", stall_err - err0);
    else n_pass++;
    tick();
  endtask

  task automatic test_bounce();
    logic [31:0] exp_d[7]  = '{0, 100, 200, 100, 0, 100, 200};
    logic [15:0] exp_sc[7] = '{0, 0, 0, 1, 1, 2, 2};
    logic [15:0] exp_si[7] = '{0, 1, 2, 0, 1, 0, 1};
    m_tready = 1'b1;
    kick(0, 200, 100, 1, 2);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if ({m_tdata, sweep_count, step_index} !== {exp_d[i], exp_sc[i], exp_si[i]})
        $display("FAIL bounce%0d got %0d sc=%0d si=%0d want %0d sc=%0d si=%0d", i,
                 m_tdata, sweep_count, step_index, exp_d[i], exp_sc[i], exp_si[i]);
      else n_pass++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if ({m_tvalid, busy, done} !== 3'b000)
      $display("FAIL bounce_abort got %b%b%b want 000", m_tvalid, busy, done);
    else n_pass++;
  endtask

  task automatic test_repeat_abort();
    logic [31:0] exp_d[5] = '{10, 20, 30, 10, 20};
    int d0;
    m_tready = 1'b1;
    kick(10, 30, 10, 1, 1);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (m_tdata !== exp_d[i]) $display("FAIL repeat%0d got %0d want %0d", i, m_tdata, exp_d[i]);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if (sweep_count !== 16'd1) $display("FAIL repeat_sc got %0d want 1", sweep_count);
        else n_pass++;
      end
      tick();
    end
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if ({m_tvalid, busy} !== 2'b00) $display("FAIL repeat_abort got %b%b want 00", m_tvalid, busy);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (done_cnt != d0) $display("FAIL repeat_nodone got %0d pulses want 0", done_cnt - d0);
    else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_total++;
    if ({busy, m_tvalid} !== 2'b00) $display("FAIL start_abort got %b%b want 00", busy, m_tvalid);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, m_tvalid} !== 2'b00) $display("FAIL start_abort_hold got %b%b want 00", busy, m_tvalid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int d0;
    m_tready = 1'b1;
    kick(0, 1000, 1, 1, 0);
    repeat (5) tick();
    d0 = done_cnt;
    arst = 1'b1;
    tick();
    arst = 1'b0;
    n_total++;
    if ({m_tdata, m_tvalid, busy, done, sweep_count, step_index} !== 67'd0)
      $display("FAIL rst_mid got %h %b%b%b %h %h want all zero",
               m_tdata, m_tvalid, busy, done, sweep_count, step_index);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (done_cnt != d0 || busy !== 1'b0)
      $display("FAIL rst_mid_after got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    else n_pass++;
  endtask

  task automatic test_step_zero();
    int bad = 0;
    m_tready = 1'b1;
    beat_q.delete();
    kick(5, 9, 0, 1, 0);
    for (int i = 0; i < 1000; i++) begin
      if (m_tdata !== 32'd5 || done !== 1'b0 || m_tvalid !== 1'b1) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL step0_hold got %0d bad cycles want 0", bad);
    else n_pass++;
    n_total++;
    if (beat_q.size() != 1000 || busy !== 1'b1)
      $display("FAIL step0_beats got n=%0d busy=%b want n=1000 busy=1", beat_q.size(), busy);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_dwell_zero();
    logic [31:0] exp_v[3] = '{7, 8, 9};
    bit seen;
    m_tready = 1'b1;
    beat_q.delete();
    kick(7, 9, 1, 0, 0);
    wait_done(50, seen);
    n_total++;
    if (!seen || beat_q.size() != 3)
      $display("FAIL dwell0_len got done=%0d n=%0d want done=1 n=3", seen, beat_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
      n_total++;
      if (beat_q[i] !== exp_v[i]) $display("FAIL dwell0_beat%0d got %0d want %0d", i, beat_q[i], exp_v[i]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_start_during_run();
    logic [31:0] exp_v[6] = '{100, 100, 200, 200, 300, 300};
    bit seen;
    m_tready = 1'b1;
    beat_q.delete();
    kick(100, 300, 100, 2, 0);
    tick();
    cfg_start_inc = 32'd0;
    cfg_mode      = 2'd1;
    cfg_step_inc  = 32'd7;
    start         = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, seen);
    n_total++;
    if (!seen || beat_q.size() != 6 || sweep_count !== 16'd1)
      $display("FAIL rerun_len got done=%0d n=%0d sc=%0d want done=1 n=6 sc=1",
               seen, beat_q.size(), sweep_count);
    else n_pass++;
    for (int i = 0; i < 6 && i < beat_q.size(); i++) begin
      n_total++;
      if (beat_q[i] !== exp_v[i]) $display("FAIL rerun_beat%0d got %0d want %0d", i, beat_q[i], exp_v[i]);
      else n_pass++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_clamp_down_overflow();
    test_backpressure();
    test_bounce();
    test_repeat_abort();
    test_reset_mid_run();
    test_step_zero();
    test_dwell_zero();
    test_start_during_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
